// File: rtl/cache_ctrl_pkg.sv
// Shared cache-control definitions: arbitration modes, width defaults, clog2 helper.
// Imported by the replacement-request merge and its arbiter.
package cache_ctrl_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Way/index encoding used throughout cache control is 3 bits wide.
    localparam int DEF_W = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmerge_arb.sv
// N-way request arbiter: fixed priority (channel 0 highest) or round-robin from ptr.
// Latency: purely combinational, grant valid in the same cycle as req.
// Backpressure: none here; the caller qualifies gnt with its own push condition.
module cmerge_arb
    import cache_ctrl_pkg::*;
#(
    parameter int N   = 3,
    parameter int IDW = clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  arb_mode_e      mode,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    int   base;
    int   idx;
    logic found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        base   = (mode == ARB_RR) ? int'(ptr) : 0;
        // Scan N slots starting at base; first requester found wins.
        for (int i = 0; i < N; i++) begin
            idx = base + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                gnt_id      = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/cmerge_arb_fifo.sv
// Merges N request channels into one stream through a DEPTH-entry FIFO tagged with source id.
// Latency: 1 cycle from accept (o_free) to head valid; no fall-through.
// Backpressure: accept stalls while the FIFO is full; downstream pops with i_freeNext.
module cmerge_arb_fifo
    import cache_ctrl_pkg::*;
#(
    parameter int N     = 3,
    parameter int W     = DEF_W,
    parameter int DEPTH = 4,
    parameter int RR    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               i_drive,
    input  logic [N*W-1:0]             i_data,
    output logic [N-1:0]               o_free,
    output logic                       o_driveNext,
    output logic [W-1:0]               o_data,
    output logic [clog2(N)-1:0]        o_srcId,
    input  logic                       i_freeNext,
    output logic [clog2(DEPTH):0]      o_count
);

    localparam int IDW = clog2(N);
    localparam int AW  = clog2(DEPTH);
    localparam int CW  = AW + 1;

    typedef struct packed {
        logic [IDW-1:0] src;
        logic [W-1:0]   dat;
    } entry_t;

    entry_t         mem [DEPTH];
    entry_t         head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_nxt;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic [W-1:0]   wr_dat;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    arb_mode_e      mode;

    assign mode = (RR == 1) ? ARB_RR : ARB_FIXED;

    cmerge_arb #(
        .N   (N),
        .IDW (IDW)
    ) u_arb (
        .req    (i_drive),
        .ptr    (rr_ptr),
        .mode   (mode),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Reset gates push so o_free reads zero while rst is low, independent of count.
    assign push   = rst && (|i_drive) && !full;
    assign pop    = !empty && i_freeNext;
    assign o_free = push ? gnt : '0;

    always_comb begin
        wr_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                wr_dat = i_data[k*W +: W];
            end
        end
    end

    assign rr_nxt = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + IDW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rr_ptr <= rr_nxt;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty masks the head outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{src: gnt_id, dat: wr_dat};
        end
    end

    assign head        = mem[rd_ptr];
    assign o_driveNext = !empty;
    assign o_data      = empty ? '0 : head.dat;
    assign o_srcId     = empty ? '0 : head.src;
    assign o_count     = count;

endmodule
